sdp_rd_arb: RTL and testbench
=============================

# sdp_rd_arb

Two-requester arbiter that shares the single read port of the simple dual-port RAM (`sdp`) between two independent read clients. It accepts read addresses on two dti consumer ports and forwards one per cycle to the memory's `rd_addr_if`. It tracks which client issued each outstanding read in an in-order tag FIFO, and steers each returning `rd_data_if` word back to its originating client. It sits directly in front of `sdp`; the write port is untouched.

## Interface
Parameters:
- `W_ADDR`, 16: read address width; matches `sdp.W_ADDR`.
- `W_DATA`, 16: read data width; matches `sdp.W_DATA`.
- `MAX_OUTST`, 4: maximum reads in flight (tag FIFO depth); must be ≥ 2 and a power of two.

Ports:
- `clk` in, 1: single clock.
- `rst` in, 1: reset; asynchronous, active-high.
- `req0_addr_if` dti.consumer, `W_ADDR`: client 0 read address.
- `req1_addr_if` dti.consumer, `W_ADDR`: client 1 read address.
- `req0_data_if` dti.producer, `W_DATA`: read data returned to client 0.
- `req1_data_if` dti.producer, `W_DATA`: read data returned to client 1.
- `mem_addr_if` dti.producer, `W_ADDR`: connects to `sdp.rd_addr_if`.
- `mem_data_if` dti.consumer, `W_DATA`: connects to `sdp.rd_data_if`.
- `outst_o` out, $clog2(`MAX_OUTST`)+1: current number of reads in flight.

## Operation
- **Handshake:** a dti transfer occurs on a cycle where valid and ready are both high. A producer holds valid and data stable until the transfer completes.
- **Issue gating:** an issue is allowed when the tag FIFO is not full, or when a response pops in the same cycle.
- **Arbitration:** `mem_addr_if.valid` = (`req0` or `req1` valid) AND issue allowed. The winner's data drives `mem_addr_if.data`.
- **Address ready:** only the winner sees `ready` = `mem_addr_if.ready` AND issue allowed. The loser sees ready = 0.
- **Round-robin (default):**
  - One-bit pointer `pri`, reset value 0, names the preferred client.
  - If both clients are valid, the preferred client wins; otherwise the sole valid client wins.
  - On each issue handshake, `pri` becomes the client that did not win.
  - While no handshake occurs, the grant does not change, so dti stability holds.
- **Tagging:** each issue handshake pushes the winner's ID (1 bit) into the tag FIFO.
- **Return path:**
  - While the FIFO is non-empty, its head ID selects the destination. `mem_data_if.data` goes to `reqN_data_if`, `reqN_data_if.valid` = `mem_data_if.valid`, and `mem_data_if.ready` = `reqN_data_if.ready`. The other client's data valid is 0.
  - A return handshake pops the FIFO.
- **Empty FIFO:** `mem_data_if.ready` = 0 and both data valids are 0.
- **Ordering:** responses return in issue order; `sdp` is in-order.
- **`outst_o`:** tracks pushes minus pops. A simultaneous push and pop leaves it unchanged.

## Timing
- The address path is combinational: zero added latency from `reqN_addr_if` to `mem_addr_if`.
- The data path is combinational: zero added latency from `mem_data_if` to `reqN_data_if`.
- Tag FIFO, `pri` and `outst_o` update on the rising edge of `clk`.
- **Throughput:** one issue and one return per cycle in steady state, including when the FIFO is full and push and pop coincide.
- **Reset values:**
  - `pri` = 0, FIFO empty, `outst_o` = 0.
  - All producer valids = 0.
  - All consumer readies: `reqN_addr_if.ready` follows the combinational rule; `mem_data_if.ready` = 0 because the FIFO is empty.
- **Reset mid-operation:** all in-flight tags are discarded. The integrator resets `sdp` on the same `rst`, so no stale response returns.

## Configuration
- **`SDP_RD_ARB_FIXED_PRIO_EN` defined:** fixed priority. Client 0 always wins when valid. `pri` is not implemented and client 1 can starve.
- **Not defined:** round-robin arbitration as described under Operation.
- Return-path behaviour is identical in both builds.

## Structure
- **Package `sdp_rd_arb_pkg`:**
  - `typedef logic req_id_t` (client ID).
  - Localparams `REQ0` = 0 and `REQ1` = 1.
  - Function `clog2p1` for the `outst_o` width.
- **Sub-module `sdp_rd_arb_tag_fifo`:**
  - Synchronous FIFO of `req_id_t`, depth `MAX_OUTST`.
  - Ports: push, pop, full, empty, head, count; async active-high reset.
  - Pointer wrap modulo `MAX_OUTST`, with one extra pointer bit for full/empty.
- The top level holds the arbiter, the `pri` register and the steering muxes.

## Test plan
- **Single client:** `req0` issues addrs 0x10, 0x11, 0x12 back-to-back; memory returns 0xA0, 0xA1, 0xA2 → `req0_data_if` receives 0xA0, 0xA1, 0xA2 in order, `req1_data_if.valid` never asserts, and `outst_o` peaks at ≤ 3.
- **Contention, round-robin:** both clients hold valid continuously, `req0` with addr 0x1, `req1` with addr 0x2 → grants alternate 0, 1, 0, 1 starting with 0 after reset. Data for 0x1 goes to `req0` and data for 0x2 to `req1`.
- **Full limit:** `MAX_OUTST` = 4 with `mem_data_if` withheld → exactly 4 issues, then both addr readies drop and `outst_o` = 4. Releasing one response in the same cycle as a new request → issue proceeds and `outst_o` stays at 4.
- **Backpressure:** head tag = 1 and `req1_data_if.ready` = 0 for 5 cycles → `mem_data_if.ready` = 0 for those 5 cycles, data held stable, no pop, and `req0_data_if.valid` = 0.
- **Fixed priority:** build with `SDP_RD_ARB_FIXED_PRIO_EN` and both clients valid for 6 cycles → all 6 grants go to `req0` and `req1` issues nothing.
- **Reset mid-flight:** assert `rst` with 3 reads outstanding → next cycle `outst_o` = 0, all valids are 0, `pri` = 0, and the first post-reset contention grants `req0`.

Source files
------------

// File: rtl/sdp_rd_arb_pkg.sv
// Shared types and helpers for the sdp read-port arbiter.
package sdp_rd_arb_pkg;

    typedef logic req_id_t;

    localparam req_id_t REQ0 = 1'b0;
    localparam req_id_t REQ1 = 1'b1;

    function automatic int clog2p1(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/dti.sv
// Valid/ready transfer interface: a transfer happens when valid and ready are both high.
interface dti #(
    parameter int W = 16
) ();
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport producer (output valid, output data, input ready);
    modport consumer (input valid, input data, output ready);
endinterface

// File: rtl/sdp_rd_arb_tag_fifo.sv
// In-order FIFO of client IDs, one entry per read in flight.
// The caller only pushes when not full or when a pop happens in the same cycle.
module sdp_rd_arb_tag_fifo
    import sdp_rd_arb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  req_id_t       i_id,
    input  logic          i_pop,
    output logic          o_full,
    output logic          o_empty,
    output req_id_t       o_head,
    output logic [AW:0]   o_count
);

    // Extra MSB on each pointer separates full from empty when the indices match.
    logic [AW:0] r_wp;
    logic [AW:0] r_rp;
    req_id_t     r_mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (i_push) r_wp <= r_wp + (AW+1)'(1);
            if (i_pop)  r_rp <= r_rp + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wp[AW-1:0]] <= i_id;
    end

    assign o_empty = (r_wp == r_rp);
    assign o_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign o_head  = r_mem[r_rp[AW-1:0]];
    assign o_count = r_wp - r_rp;

endmodule

// File: rtl/sdp_rd_arb.sv
// Two-client arbiter for the sdp read port with in-order response steering.
// Define SDP_RD_ARB_FIXED_PRIO_EN for fixed priority (client 0 wins); default is round-robin.
module sdp_rd_arb
    import sdp_rd_arb_pkg::*;
#(
    parameter int W_ADDR    = 16,
    parameter int W_DATA    = 16,
    parameter int MAX_OUTST = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    dti.consumer                             req0_addr_if,
    dti.consumer                             req1_addr_if,
    dti.producer                             req0_data_if,
    dti.producer                             req1_data_if,
    dti.producer                             mem_addr_if,
    dti.consumer                             mem_data_if,
    output logic [clog2p1(MAX_OUTST)-1:0]    outst_o
);

    logic              w_v0;
    logic              w_v1;
    logic [W_ADDR-1:0] w_a0;
    logic [W_ADDR-1:0] w_a1;
    logic [W_DATA-1:0] w_rdata;
    req_id_t           w_gnt;
    req_id_t           w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_issue_ok;
    logic              w_mvalid;
    logic              w_push;
    logic              w_mrdy;
    logic              w_pop;

    assign w_v0 = req0_addr_if.valid;
    assign w_v1 = req1_addr_if.valid;
    assign w_a0 = req0_addr_if.data;
    assign w_a1 = req1_addr_if.data;

`ifdef SDP_RD_ARB_FIXED_PRIO_EN
    assign w_gnt = w_v0 ? REQ0 : REQ1;
`else
    // r_pri only moves on an issue, so a stalled grant stays put.
    req_id_t r_pri;

    assign w_gnt = (w_v0 && w_v1) ? r_pri : (w_v1 ? REQ1 : REQ0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         r_pri <= REQ0;
        else if (w_push) r_pri <= ~w_gnt;
    end
`endif

    // A same-cycle pop frees the slot, so a full FIFO still sustains one issue per cycle.
    assign w_issue_ok = !w_full || w_pop;
    assign w_mvalid   = (w_v0 || w_v1) && w_issue_ok;
    assign w_push     = w_mvalid && mem_addr_if.ready;

    assign mem_addr_if.valid  = w_mvalid;
    assign mem_addr_if.data   = (w_gnt == REQ1) ? w_a1 : w_a0;
    assign req0_addr_if.ready = (w_gnt == REQ0) && mem_addr_if.ready && w_issue_ok;
    assign req1_addr_if.ready = (w_gnt == REQ1) && mem_addr_if.ready && w_issue_ok;

    assign w_rdata            = mem_data_if.data;
    assign req0_data_if.data  = w_rdata;
    assign req1_data_if.data  = w_rdata;
    assign req0_data_if.valid = !w_empty && (w_head == REQ0) && mem_data_if.valid;
    assign req1_data_if.valid = !w_empty && (w_head == REQ1) && mem_data_if.valid;

    assign w_mrdy            = !w_empty && ((w_head == REQ1) ? req1_data_if.ready : req0_data_if.ready);
    assign mem_data_if.ready = w_mrdy;
    assign w_pop             = w_mrdy && mem_data_if.valid;

    sdp_rd_arb_tag_fifo #(
        .DEPTH   (MAX_OUTST)
    ) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_id    (w_gnt),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head),
        .o_count (outst_o)
    );

endmodule

// File: tb/tb_sdp_rd_arb.sv
// Directed bench for sdp_rd_arb: an in-order memory model plus a scoreboard of expected returns.
module tb_sdp_rd_arb;

    typedef struct packed {
        logic        id;
        logic [15:0] d;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] outst_o;

    dti #(.W(16)) r0a ();
    dti #(.W(16)) r1a ();
    dti #(.W(16)) r0d ();
    dti #(.W(16)) r1d ();
    dti #(.W(16)) ma  ();
    dti #(.W(16)) md  ();

    sdp_rd_arb #(.W_ADDR(16), .W_DATA(16), .MAX_OUTST(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .req0_addr_if (r0a),
        .req1_addr_if (r1a),
        .req0_data_if (r0d),
        .req1_data_if (r1d),
        .mem_addr_if  (ma),
        .mem_data_if  (md),
        .outst_o      (outst_o)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] mem_q[$];
    exp_t        exp_q[$];
    logic        mem_en = 1'b0;
    logic        hs0, hs1, hsm;
    logic        s_mrdy, s_r0v, s_r1v;
    logic [15:0] s_r1d;
    logic        r1v_seen;
    int          max_outst;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive the memory model, sample at negedge, score handshakes, advance.
    task automatic cycle();
        exp_t e;
        logic r0h, r1h, mh;
        md.valid = mem_en && (mem_q.size() != 0);
        md.data  = (mem_q.size() != 0) ? mem_q[0] : 16'h0;
        @(negedge clk);
        chk("outst", 32'(outst_o), 32'(exp_q.size()));
        if (32'(outst_o) > max_outst) max_outst = 32'(outst_o);
        r1v_seen |= r1d.valid;
        hs0 = r0a.valid & r0a.ready;
        hs1 = r1a.valid & r1a.ready;
        hsm = ma.valid & ma.ready;
        chk("issue_route", hsm, hs0 | hs1);
        chk("one_gnt", hs0 & hs1, 0);
        r0h = r0d.valid & r0d.ready;
        r1h = r1d.valid & r1d.ready;
        mh  = md.valid & md.ready;
        chk("ret_route", r0h | r1h, mh);
        chk("ret_one", r0h & r1h, 0);
        s_mrdy = md.ready;
        s_r0v  = r0d.valid;
        s_r1v  = r1d.valid;
        s_r1d  = r1d.data;
        if (mh && mem_q.size() != 0) void'(mem_q.pop_front());
        if (r0h | r1h) begin
            if (exp_q.size() == 0) chk("ret_extra", 32'(exp_q.size()), 1);
            else begin
                e = exp_q.pop_front();
                chk("ret_id", r1h, e.id);
                chk("ret_data", r1h ? r1d.data : r0d.data, e.d);
            end
        end
        if (hsm) begin
            chk("maddr", ma.data, hs1 ? r1a.data : r0a.data);
            mem_q.push_back(ma.data + 16'h90);
            e.id = hs1;
            e.d  = (hs1 ? r1a.data : r0a.data) + 16'h90;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue0(input logic [15:0] a);
        bit done = 0;
        r0a.valid = 1'b1;
        r0a.data  = a;
        for (int i = 0; i < 20 && !done; i++) begin
            cycle();
            done = hs0;
        end
        chk("issue0_timeout", done, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) cycle();
        chk("drain", 32'(exp_q.size()), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_outst", 32'(outst_o), 0);
        chk("rst_r0dv", r0d.valid, 0);
        chk("rst_r1dv", r1d.valid, 0);
        chk("rst_mdrdy", md.ready, 0);
        @(posedge clk);
        #1;
        mem_q.delete();
        exp_q.delete();
        md.valid = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        r0a.valid = 0; r0a.data = 0;
        r1a.valid = 0; r1a.data = 0;
        r0d.ready = 1; r1d.ready = 1;
        ma.ready  = 1;
        md.valid  = 0; md.data = 0;

        // Reset state
        @(posedge clk); #1;
        chk("rst_mavalid", ma.valid, 0);
        do_reset();

        // Single client: three back-to-back reads on req0
        mem_en = 1; r1v_seen = 0; max_outst = 0;
        issue0(16'h10);
        issue0(16'h11);
        issue0(16'h12);
        r0a.valid = 0;
        drain();
        chk("single_r1v", r1v_seen, 0);
        chk("single_peak", max_outst <= 3, 1);

        // Contention from reset: round-robin alternates, fixed priority always picks req0
        do_reset();
        r0a.valid = 1; r0a.data = 16'h1;
        r1a.valid = 1; r1a.data = 16'h2;
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk($sformatf("cont_hs%0d", i), hs0 | hs1, 1);
`ifdef SDP_RD_ARB_FIXED_PRIO_EN
            chk($sformatf("cont_gnt%0d", i), hs1, 0);
`else
            chk($sformatf("cont_gnt%0d", i), hs1, i % 2);
`endif
        end
        r0a.valid = 0; r1a.valid = 0;
        drain();

        // Full limit with responses withheld
        mem_en = 0;
        r1a.valid = 1; r1a.data = 16'h20;
        begin
            int n_hs = 0;
            for (int i = 0; i < 6; i++) begin
                cycle();
                n_hs += int'(hs1);
            end
            chk("full_issues", n_hs, 4);
        end
        chk("full_outst", 32'(outst_o), 4);
        chk("full_r1rdy", r1a.ready, 0);
        chk("full_r0rdy", r0a.ready, 0);
        chk("full_mavalid", ma.valid, 0);
        mem_en = 1;
        cycle();
        chk("full_swap_issue", hs1, 1);
        chk("full_swap_ret", s_r1v, 1);
        chk("full_swap_outst", 32'(outst_o), 4);
        r1a.valid = 0;

        // Backpressure on client 1 with head tag 1
        r1d.ready = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk($sformatf("bp_mrdy%0d", i), s_mrdy, 0);
            chk($sformatf("bp_r1v%0d", i), s_r1v, 1);
            chk($sformatf("bp_r0v%0d", i), s_r0v, 0);
            chk($sformatf("bp_data%0d", i), s_r1d, 16'hB0);
        end
        chk("bp_outst", 32'(outst_o), 4);
        r1d.ready = 1;
        drain();

        // Reset with three reads in flight
        mem_en = 0;
        issue0(16'h30);
        issue0(16'h31);
        issue0(16'h32);
        r0a.valid = 0;
        cycle();
        chk("mid_outst", 32'(outst_o), 3);
        md.valid = 1; md.data = 16'hC0;
        do_reset();
        chk("post_mavalid", ma.valid, 0);
        r0a.valid = 1; r0a.data = 16'h40;
        r1a.valid = 1; r1a.data = 16'h41;
        cycle();
        chk("post_gnt0", hs0, 1);
        r0a.valid = 0; r1a.valid = 0;
        mem_en = 1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
